// File: rtl/calc_display_arbiter.sv
// calc_display_arbiter
//   Shares one 8-digit seven-segment display between live operand entry,
//   the latched result and an error indication. It also generates the
//   scan clock for the digit-multiplexing driver.
//
// Parameters
//   SCAN_DIV     core cycles per scan-clock half-period (1..2^24-1)
//   HOLD_CYCLES  cycles a result/error stays visible (1..2^32-1)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   opa_data     operand A, 8 hex nibbles
//   opb_data     operand B, 8 hex nibbles
//   b_sel        1 = operand B being edited, 0 = operand A
//   res_data     calculation result
//   res_valid    single-cycle pulse, res_data valid
//   err          single-cycle pulse, operation error
//   disp_n       registered word to the display driver (digit 7 = [31:28])
//   disp_clk     scan clock, 50% duty, period 2*SCAN_DIV cycles
//   src          0 = live A, 1 = live B, 2 = result, 3 = error
//   hold_active  1 while a result or error is being held
module calc_display_arbiter #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned HOLD_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] opa_data,
    input  logic [31:0] opb_data,
    input  logic        b_sel,
    input  logic [31:0] res_data,
    input  logic        res_valid,
    input  logic        err,
    output logic [31:0] disp_n,
    output logic        disp_clk,
    output logic [1:0]  src,
    output logic        hold_active
);

    typedef enum logic [1:0] {
        S_LIVE = 2'd0,
        S_RES  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [31:0] HOLD_LD  = 32'(HOLD_CYCLES - 1);
    localparam logic [23:0] PRE_LAST = 24'(SCAN_DIV - 1);
    localparam logic [31:0] ERR_WORD = 32'hEEEE_EEEE;

    state_t      r_state;
    logic [31:0] r_hold_cnt;
    logic [31:0] r_res_reg;
    logic        r_res_pend;
    logic [31:0] r_disp;
    logic [1:0]  r_src;
    logic        r_hold_active;
    logic [23:0] r_pre;
    logic        r_disp_clk;

    logic [31:0] w_live;
    logic        w_hold_done;

    assign w_live      = b_sel ? opb_data : opa_data;
    assign w_hold_done = (r_hold_cnt == 32'd0);

    // State and display outputs are updated together from the next-state
    // decision, so a pulse is visible on the same edge that samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_LIVE;
            r_hold_cnt    <= 32'd0;
            r_res_reg     <= 32'd0;
            r_res_pend    <= 1'b0;
            r_disp        <= 32'd0;
            r_src         <= 2'd0;
            r_hold_active <= 1'b0;
        end else if (err) begin
            // Error wins over everything; a simultaneous result queues
            // behind it.
            r_state       <= S_ERR;
            r_hold_cnt    <= HOLD_LD;
            r_disp        <= ERR_WORD;
            r_src         <= 2'd3;
            r_hold_active <= 1'b1;
            if (res_valid) begin
                r_res_reg  <= res_data;
                r_res_pend <= 1'b1;
            end
        end else if (res_valid && r_state != S_ERR) begin
            // New result from LIVE or RES: (re)start the full hold window.
            r_state       <= S_RES;
            r_hold_cnt    <= HOLD_LD;
            r_res_reg     <= res_data;
            r_disp        <= res_data;
            r_src         <= 2'd2;
            r_hold_active <= 1'b1;
        end else if (r_state != S_LIVE) begin
            // Holding. A result arriving during ERR is latched but does not
            // stretch the error window; it is shown once ERR expires.
            if (res_valid)
                r_res_reg <= res_data;
            if (w_hold_done) begin
                if (r_state == S_ERR && (r_res_pend || res_valid)) begin
                    r_state       <= S_RES;
                    r_hold_cnt    <= HOLD_LD;
                    r_res_pend    <= 1'b0;
                    r_disp        <= res_valid ? res_data : r_res_reg;
                    r_src         <= 2'd2;
                    r_hold_active <= 1'b1;
                end else begin
                    r_state       <= S_LIVE;
                    r_disp        <= w_live;
                    r_src         <= {1'b0, b_sel};
                    r_hold_active <= 1'b0;
                end
            end else begin
                r_hold_cnt <= r_hold_cnt - 32'd1;
                if (res_valid)
                    r_res_pend <= 1'b1;
            end
        end else begin
            r_disp        <= w_live;
            r_src         <= {1'b0, b_sel};
            r_hold_active <= 1'b0;
        end
    end

    // Free-running scan prescaler; disp_clk flips on every wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre      <= 24'd0;
            r_disp_clk <= 1'b0;
        end else if (r_pre == PRE_LAST) begin
            r_pre      <= 24'd0;
            r_disp_clk <= ~r_disp_clk;
        end else begin
            r_pre <= r_pre + 24'd1;
        end
    end

    assign disp_n      = r_disp;
    assign disp_clk    = r_disp_clk;
    assign src         = r_src;
    assign hold_active = r_hold_active;

endmodule

// File: tb/tb_calc_display_arbiter.sv
module tb_calc_display_arbiter;

    localparam int SD = 3;
    localparam int H  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] opa, opb, res_data;
    logic        b_sel, res_valid, err;

    logic [31:0] disp_n, d1_disp;
    logic        disp_clk, d1_clk;
    logic [1:0]  src, d1_src;
    logic        hold_active, d1_ha;

    always #5 clk = ~clk;

    calc_display_arbiter #(.SCAN_DIV(SD), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst_n(rst_n), .opa_data(opa), .opb_data(opb), .b_sel(b_sel),
        .res_data(res_data), .res_valid(res_valid), .err(err),
        .disp_n(disp_n), .disp_clk(disp_clk), .src(src), .hold_active(hold_active)
    );

    // Boundary instance: one-cycle hold, scan clock toggling every cycle.
    calc_display_arbiter #(.SCAN_DIV(1), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .opa_data(opa), .opb_data(opb), .b_sel(b_sel),
        .res_data(res_data), .res_valid(res_valid), .err(err),
        .disp_n(d1_disp), .disp_clk(d1_clk), .src(d1_src), .hold_active(d1_ha)
    );

    int checks = 0;
    int failures = 0;

    // Reference model, timestamp based: n = edges since reset release,
    // err_end/res_end = first edge at which that display is no longer shown.
    int          n;
    int          err_end, res_end;
    bit          pend;
    logic [31:0] resv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; err_end = 0; res_end = 0; pend = 0; resv = 32'd0;
    endtask

    task automatic chk_zero();
        chk("rst_disp", disp_n, 32'd0);
        chk("rst_src", 32'(src), 32'd0);
        chk("rst_hold", 32'(hold_active), 32'd0);
        chk("rst_clk", 32'(disp_clk), 32'd0);
        chk("rst_d1_disp", d1_disp, 32'd0);
    endtask

    task automatic check_all();
        logic [31:0] e_disp;
        logic [1:0]  e_src;
        logic        e_ha;
        if (n < err_end) begin
            e_disp = 32'hEEEE_EEEE; e_src = 2'd3; e_ha = 1'b1;
        end else if (n < res_end) begin
            e_disp = resv; e_src = 2'd2; e_ha = 1'b1;
        end else begin
            e_disp = b_sel ? opb : opa; e_src = {1'b0, b_sel}; e_ha = 1'b0;
        end
        chk("disp", disp_n, e_disp);
        chk("src", 32'(src), 32'(e_src));
        chk("hold", 32'(hold_active), 32'(e_ha));
        chk("scan", 32'(disp_clk), 32'((n / SD) % 2));
        chk("d1_scan", 32'(d1_clk), 32'(n % 2));
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        if (err) begin
            err_end = n + H;
            res_end = 0;
            if (res_valid) begin resv = res_data; pend = 1; end
        end else if (res_valid) begin
            resv = res_data;
            if (n < err_end) pend = 1;
            else begin res_end = n + H; pend = 0; end
        end else if (pend && n == err_end) begin
            res_end = n + H;
            pend = 0;
        end
        #1 check_all();
    endtask

    initial begin
        opa = 32'h1234_5678; opb = 32'h0000_00AB; b_sel = 1'b0;
        res_data = 32'd0; res_valid = 1'b0; err = 1'b0;
        model_reset();

        // Reset state
        #12 chk_zero();
        @(negedge clk) rst_n = 1'b1;

        // Scan clock: rises at edge 3, falls at edge 6
        step(); chk("live_a", disp_n, 32'h1234_5678);
        step();
        step(); chk("scan_rise", 32'(disp_clk), 32'd1);
        step(); step();
        step(); chk("scan_fall", 32'(disp_clk), 32'd0);

        // Live switch to B
        b_sel = 1'b1;
        step(); chk("live_b", disp_n, 32'h0000_00AB); chk("live_b_src", 32'(src), 32'd1);

        // Result hold
        res_valid = 1'b1; res_data = 32'h42;
        step(); res_valid = 1'b0;
        chk("res_42", disp_n, 32'h42); chk("res_src", 32'(src), 32'd2);
        chk("d1_res", d1_disp, 32'h42); chk("d1_res_src", 32'(d1_src), 32'd2);
        step(); chk("d1_live", 32'(d1_src), 32'd1);
        step(); step();
        chk("res_k3", 32'(hold_active), 32'd1);
        step(); chk("res_end", 32'(src), 32'd1); chk("res_end_ha", 32'(hold_active), 32'd0);

        // Retrigger
        res_valid = 1'b1; res_data = 32'h11;
        step(); res_valid = 1'b0;
        step();
        res_valid = 1'b1; res_data = 32'h99;
        step(); res_valid = 1'b0;
        chk("retrig", disp_n, 32'h99);
        step();
        step(); chk("retrig_k4", 32'(src), 32'd2);
        step(); chk("retrig_k5", 32'(src), 32'd2);
        step(); chk("retrig_k6", 32'(src), 32'd1);

        // Error with simultaneous result
        err = 1'b1; res_valid = 1'b1; res_data = 32'h77;
        step(); err = 1'b0; res_valid = 1'b0;
        chk("err_word", disp_n, 32'hEEEE_EEEE); chk("d1_err", 32'(d1_src), 32'd3);
        step(); chk("d1_pend", d1_disp, 32'h77);
        step(); chk("d1_back", 32'(d1_src), 32'd1);
        step();
        step(); chk("pend_77", disp_n, 32'h77); chk("pend_src", 32'(src), 32'd2);
        step(); step(); step();
        step(); chk("pend_end", 32'(src), 32'd1);

        // Asynchronous reset mid-hold
        res_valid = 1'b1; res_data = 32'h55;
        step(); res_valid = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1 chk_zero();
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        step(); chk("post_rst_live", disp_n, opb);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            opa       = $urandom;
            opb       = $urandom;
            b_sel     = 1'($urandom_range(0, 1));
            res_data  = $urandom;
            res_valid = ($urandom_range(0, 7) == 0);
            err       = ($urandom_range(0, 15) == 0);
            step();
        end
        res_valid = 1'b0; err = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
